// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the physical clock-divider generator:
// FSM state encoding, default ratio width and the ratio clamp.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int unsigned DIV_W_DEF = 4;

  // A ratio of zero behaves as divide-by-one.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
    return (ratio == '0) ? 32'd1 : ratio;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, clock-enable strobe, duty output and drain park/done.
// The duty output exists only when PHYSICAL_CLK_DIV_DUTY_OUT_EN is defined; otherwise it is tied low.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state,
  input  state_t           state_nxt,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce,
  output logic             clk_div,
  output logic             done
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_d;
  logic             ce_d;
  logic             done_d;
  logic             terminal;

  assign terminal = (cnt == ratio - DIV_W'(1));

  // Outputs are registered from the upcoming state so they line up with cnt.
  always_comb begin
    cnt_d  = '0;
    ce_d   = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      ST_RUN: begin
        if (state == ST_RUN) begin
          cnt_d = terminal ? '0 : cnt + DIV_W'(1);
          ce_d  = terminal;
        end else begin
          ce_d  = (ratio == DIV_W'(1));
        end
      end
      ST_DRAIN: begin
        if (done || terminal) done_d = 1'b1;
        else                  cnt_d  = cnt + DIV_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      ce   <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      ce   <= ce_d;
      done <= done_d;
    end
  end

`ifdef PHYSICAL_CLK_DIV_DUTY_OUT_EN
  logic [DIV_W:0] half;
  logic           hi_d;

  assign half = ({1'b0, ratio} + (DIV_W+1)'(1)) >> 1;

  always_comb begin
    hi_d = 1'b0;
    if (state_nxt == ST_RUN || (state_nxt == ST_DRAIN && !done_d))
      hi_d = ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk) begin
    if (rst) clk_div <= 1'b0;
    else     clk_div <= hi_d;
  end
`else
  assign clk_div = 1'b0;
`endif

endmodule

// File: rtl/physical_clk_div_gen.sv
// Multi-channel clock divider with shadowed ratio reload, drain-to-park and phase realignment.
// Optional duty-cycle outputs are enabled by defining PHYSICAL_CLK_DIV_DUTY_OUT_EN.
module physical_clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned                N_CH     = 3,
  parameter int unsigned                DIV_W    = DIV_W_DEF,
  parameter logic [N_CH*DIV_W-1:0]      DIV_INIT = 12'h153
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH*DIV_W-1:0] i_div,
  input  logic                  i_div_load,
  input  logic                  i_sync,
  output logic [N_CH-1:0]       o_ce,
  output logic [N_CH-1:0]       o_clk_div,
  output logic                  o_ready
);

  state_t          state;
  state_t          state_nxt;
  logic [N_CH-1:0] done;
  logic            all_done;
  logic            drain_exit;

  assign all_done   = &done;
  assign drain_exit = (state == ST_DRAIN) && all_done;
  assign o_ready    = (state == ST_RUN);

  // A load in RUN wins over a simultaneous sync; the sync is simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_ALIGN;
      ST_ALIGN: state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_div_load)  state_nxt = ST_DRAIN;
        else if (i_sync) state_nxt = ST_ALIGN;
      end
      ST_DRAIN: if (all_done) state_nxt = ST_ALIGN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_RESET;
    else       state <= state_nxt;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_W-1:0] init_ratio;
    logic [DIV_W-1:0] req_ratio;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] shadow;

    assign init_ratio = DIV_W'(clamp_ratio(32'(DIV_INIT[g*DIV_W +: DIV_W])));
    assign req_ratio  = DIV_W'(clamp_ratio(32'(i_div[g*DIV_W +: DIV_W])));

    // Active takes the pre-edge shadow on drain exit; a same-cycle load only refreshes shadow.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        active <= init_ratio;
        shadow <= init_ratio;
      end else begin
        if (drain_exit) active <= shadow;
        if (i_div_load) shadow <= req_ratio;
      end
    end

    clk_div_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (i_clk),
      .rst       (i_rst),
      .state     (state),
      .state_nxt (state_nxt),
      .ratio     (active),
      .ce        (o_ce[g]),
      .clk_div   (o_clk_div[g]),
      .done      (done[g])
    );
  end

endmodule

// File: tb/tb_physical_clk_div_gen.sv
// Scoreboard bench for physical_clk_div_gen: a cycle-level behavioural model predicts every output cycle.
module tb_physical_clk_div_gen;

  localparam int N_CH  = 3;
  localparam int DIV_W = 4;
  localparam int DW    = N_CH * DIV_W;
  localparam logic [DW-1:0] DIV_INIT = 12'h153;

  localparam int M_RESET = 0;
  localparam int M_ALIGN = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [DW-1:0]   i_div = '0;
  logic            i_div_load = 1'b0;
  logic            i_sync = 1'b0;
  logic [N_CH-1:0] o_ce;
  logic [N_CH-1:0] o_clk_div;
  logic            o_ready;

  physical_clk_div_gen #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DIV_INIT(DIV_INIT)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_div     (i_div),
    .i_div_load(i_div_load),
    .i_sync    (i_sync),
    .o_ce      (o_ce),
    .o_clk_div (o_clk_div),
    .o_ready   (o_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic            ready;
    logic [N_CH-1:0] ce;
    logic [N_CH-1:0] clk_div;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Model: operating mode, cycles since RUN entry, drain progress and ratios.
  int mode = M_RESET;
  int age  = 0;
  int dj   = 0;
  int dlen = 0;
  int ratio  [N_CH];
  int shadow [N_CH];
  int pos    [N_CH];

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge(input logic rst, input logic load, input logic sync,
                            input logic [DW-1:0] div);
    int nxt [N_CH];
    logic [DW-1:0] init_v;
    init_v = DIV_INIT;
    for (int ch = 0; ch < N_CH; ch++) nxt[ch] = clamp(int'(div[ch*DIV_W +: DIV_W]));
    if (rst) begin
      mode = M_RESET;
      for (int ch = 0; ch < N_CH; ch++) begin
        ratio[ch]  = clamp(int'(init_v[ch*DIV_W +: DIV_W]));
        shadow[ch] = ratio[ch];
      end
      return;
    end
    case (mode)
      M_RESET: mode = M_ALIGN;
      M_ALIGN: begin mode = M_RUN; age = 0; end
      M_RUN: begin
        if (load) begin
          // Each channel finishes its period: N - phase cycles until parked.
          mode = M_DRAIN; dj = 1; dlen = 0;
          for (int ch = 0; ch < N_CH; ch++) begin
            pos[ch] = age % ratio[ch];
            if (ratio[ch] - pos[ch] > dlen) dlen = ratio[ch] - pos[ch];
          end
        end else if (sync) mode = M_ALIGN;
        else age++;
      end
      default: begin
        if (dj == dlen) begin
          mode = M_ALIGN;
          for (int ch = 0; ch < N_CH; ch++) ratio[ch] = shadow[ch];
        end else dj++;
      end
    endcase
    if (load) for (int ch = 0; ch < N_CH; ch++) shadow[ch] = nxt[ch];
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   ph;
    int   c;
    e = '0;
    if (mode == M_RUN) begin
      e.ready = 1'b1;
      for (int ch = 0; ch < N_CH; ch++) begin
        ph = age % ratio[ch];
        e.ce[ch]      = (ratio[ch] == 1) || (age > 0 && ph == 0);
        e.clk_div[ch] = ph < (ratio[ch] + 1) / 2;
      end
    end else if (mode == M_DRAIN) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        c = pos[ch] + dj;
        if (c <= ratio[ch] - 1) e.clk_div[ch] = c < (ratio[ch] + 1) / 2;
      end
    end
`ifndef PHYSICAL_CLK_DIV_DUTY_OUT_EN
    e.clk_div = '0;
`endif
    return e;
  endfunction

  task automatic step(input logic rst, input logic load, input logic sync,
                      input logic [DW-1:0] div);
    i_rst = rst; i_div_load = load; i_sync = sync; i_div = div;
    @(posedge i_clk); #1;
    cycle++;
    model_edge(rst, load, sync, div);
    exp_q.push_back(model_out());
    i_div_load = 1'b0; i_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Idle until channel ch sits at counter phase p in RUN, bounded.
  task automatic wait_phase(input int ch, input int p);
    int k;
    k = 0;
    while (!(mode == M_RUN && (age % ratio[ch]) == p) && k < 64) begin
      step(1'b0, 1'b0, 1'b0, '0);
      k++;
    end
    checks++;
    if (!(mode == M_RUN && (age % ratio[ch]) == p)) begin
      failures++;
      $display("FAIL wait_phase ch=%0d got_mode=%0d required_phase=%0d", ch, mode, p);
    end
  endtask

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("o_ready",   int'(o_ready),   int'(e.ready));
        cmp("o_ce",      int'(o_ce),      int'(e.ce));
        cmp("o_clk_div", int'(o_clk_div), int'(e.clk_div));
      end
    end
  end

  initial begin : stimulus
    logic [DW-1:0] rdiv;
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    idle(24);                                   // reset release at DIV_INIT ratios
    step(1'b0, 1'b0, 1'b1, '0); idle(8);        // realign
    step(1'b0, 1'b1, 1'b0, 12'h000); idle(20);  // zero ratios act as one
    step(1'b0, 1'b1, 1'b0, 12'h153); idle(12);
    wait_phase(1, 1);
    step(1'b0, 1'b1, 1'b0, 12'h173); idle(30);  // ch1 -> 7 from phase 1
    step(1'b0, 1'b1, 1'b1, 12'h153); idle(20);  // load beats sync
    wait_phase(0, 0);
    step(1'b0, 1'b1, 1'b0, 12'h154);
    step(1'b0, 1'b1, 1'b0, 12'h156); idle(30);  // last write wins
    wait_phase(0, 0);
    step(1'b0, 1'b1, 1'b0, 12'h777);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0); idle(20);       // reset mid-drain
    for (int k = 0; k < 400; k++) begin
      rdiv = DW'($urandom());
      step(($urandom_range(79) == 0), ($urandom_range(9) == 0), ($urandom_range(7) == 0), rdiv);
    end
    idle(2);
    @(negedge i_clk); #1;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/physical_clk_div_gen.md
PHYSICAL_CLK_DIV_GEN -- requirements
Module: physical_clk_div_gen

Interface
- REQ-001: Parameter N_CH, 3, number of independent divider channels (1..8).
- REQ-002: Parameter DIV_W, 4, bit width of each channel's divide ratio.
- REQ-003: Parameter DIV_INIT, 12'h153, per-channel initial ratio, packed with ch0 in the LSBs (ch0=3, ch1=5, ch2=1).
- REQ-004: The block SHALL use one clock and a synchronous, active-high reset: i_clk samples all logic and i_rst is synchronous to i_clk.
- REQ-005: i_clk  in  1  fabric clock; all logic on rising edge.
- REQ-006: i_rst  in  1  synchronous active-high reset.
- REQ-007: i_div  in  N_CH*DIV_W  requested ratios, packed with ch0 in the LSBs.
- REQ-008: i_div_load  in  1  one-cycle strobe that captures i_div into the shadow register.
- REQ-009: i_sync  in  1  one-cycle strobe requesting phase realignment of all channels.
- REQ-010: o_ce  out  N_CH  per-channel clock-enable strobe, one cycle per period.
- REQ-011: o_clk_div  out  N_CH  per-channel divided square wave, registered.
- REQ-012: o_ready  out  1  high only in RUN, when all channels are phase-aligned at the active ratios.

Function
- REQ-013: Ratio 0 SHALL be treated as 1 (clamped at both capture and DIV_INIT decode).
- REQ-014: Channel counter SHALL count 0..N-1 and wrap; o_ce=1 in the cycle after cnt==N-1 (registered); for N=1, o_ce SHALL be constant 1 in RUN.
- REQ-015: o_clk_div SHALL be high while cnt < (N+1)/2 (integer division), giving 3 -> 2 high/1 low and 5 -> 3 high/2 low; for N=1 it SHALL be held high in RUN.
- REQ-016: FSM states SHALL be RESET, ALIGN, RUN and DRAIN.
- REQ-017: RESET -> ALIGN on the first cycle with i_rst=0; ALIGN -> RUN after exactly one cycle; all counters SHALL be 0 on RUN entry.
- REQ-018: In RUN, i_sync=1 SHALL force ALIGN next cycle; o_ready=0 for that one cycle.
- REQ-019: In RUN, i_div_load=1 SHALL capture the shadow register and enter DRAIN next cycle; with simultaneous i_sync, the load SHALL take priority and the sync SHALL be dropped.
- REQ-020: In DRAIN, each channel SHALL finish its current period; on reaching its terminal count it SHALL park with cnt=0, o_ce=0, o_clk_div=0 and set done; an N=1 channel SHALL be done immediately.
- REQ-021: When all channels are done, the FSM SHALL go to ALIGN and load the active ratios from the shadow register in that same cycle.
- REQ-022: i_div_load in DRAIN or ALIGN SHALL overwrite the shadow register (last write wins) without restarting the drain; i_sync in DRAIN or ALIGN SHALL be ignored.
- REQ-023: DRAIN latency SHALL be at most max(active N) cycles.
- REQ-024: Outside RUN and DRAIN, o_ce and o_clk_div SHALL be 0.

Reset
- REQ-025: On i_rst=1: state=RESET, all counters=0, o_ce=0, o_clk_div=0, o_ready=0, active and shadow ratios = clamped DIV_INIT.
- REQ-026: Reset asserted in any state, including mid-DRAIN, SHALL take effect on the next edge and discard any pending shadow value.

Configuration
- REQ-027: Macro PHYSICAL_CLK_DIV_DUTY_OUT_EN: when defined, o_clk_div SHALL be generated per REQ-015.
- REQ-028: When PHYSICAL_CLK_DIV_DUTY_OUT_EN is undefined, o_clk_div SHALL be tied to 0, its logic omitted, and o_ce behaviour unchanged.

Structure
- REQ-029: Package clk_div_pkg SHALL hold the FSM state encoding, the DIV_W default and the ratio clamp function.
- REQ-030: Sub-module clk_div_channel (counter, o_ce, o_clk_div, park/done logic) SHALL be instantiated N_CH times.

Verification
- REQ-031: Reset release with DIV_INIT=12'h153 -> o_ready=1 from cycle 2; ch0 o_ce every 3 cycles, ch1 every 5, ch2 constant 1; ch0 o_clk_div pattern 110.
- REQ-032: Ratios 0 loaded on all channels -> behaviour identical to ratio 1 on every channel.
- REQ-033: i_div_load with ch1=7 while ch1 cnt=1 -> DRAIN for 4 more cycles, then ALIGN, then RUN; ch1 o_ce every 7 cycles; o_ready low throughout the drain and align.
- REQ-034: i_sync and i_div_load in the same cycle -> DRAIN taken; no extra ALIGN cycle occurs.
- REQ-035: Second i_div_load during DRAIN (ch0=4, then ch0=6) -> ch0 runs at 6 after RUN re-entry.
- REQ-036: i_rst asserted mid-DRAIN -> all outputs 0 next cycle; after release, DIV_INIT ratios restored; run once with PHYSICAL_CLK_DIV_DUTY_OUT_EN undefined -> o_clk_div stays 0.
